// File: rtl/shift_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined shift/rotate unit.
// The layer split helpers spread the mux layers over the stages, larger shares first.
package shift_pipe_pkg;

  localparam logic [1:0] SHIFT_OP_SLL  = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL  = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA  = 2'b10;
  localparam logic [1:0] SHIFT_OP_ROTR = 2'b11;

  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

  // Number of mux layers handled by stage idx; the first (total % stages) stages take one extra.
  function automatic int stage_num_layers(input int total, input int stages, input int idx);
    return (total / stages) + ((idx < (total % stages)) ? 1 : 0);
  endfunction

  function automatic int stage_first_layer(input int total, input int stages, input int idx);
    int rem;
    rem = total % stages;
    return idx * (total / stages) + ((idx < rem) ? idx : rem);
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline stage of the shift unit: a run of log-shifter mux layers followed by
// the stage register, with its own valid bit and advance (stall) logic.
module shift_stage
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FIRST_LAYER = 0,
  parameter int NUM_LAYERS  = 1,
  parameter int TAG_W       = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      up_valid,
  input  logic [1:0]                up_op,
  input  logic [$clog2(WIDTH)-1:0]  up_shamt,
  input  logic [WIDTH-1:0]          up_data,
  input  logic [TAG_W-1:0]          up_tag,
  input  logic                      down_advance,
  output logic                      advance,
  output logic                      valid,
  output logic [1:0]                op,
  output logic [$clog2(WIDTH)-1:0]  shamt,
  output logic [WIDTH-1:0]          data,
  output logic [TAG_W-1:0]          tag
);

  localparam int SW = $clog2(WIDTH);

  logic              valid_r;
  logic [1:0]        op_r;
  logic [SW-1:0]     shamt_r;
  logic [WIDTH-1:0]  data_r;
  logic [TAG_W-1:0]  tag_r;
  logic [WIDTH-1:0]  shifted_s;

  // A single layer: fixed power-of-two move. SRA keeps the MSB, which is the
  // operand sign captured at entry because earlier layers never change it.
  function automatic logic [WIDTH-1:0] layer_shift(input logic [1:0] l_op,
                                                   input logic [WIDTH-1:0] d,
                                                   input int amt);
    logic [WIDTH-1:0] r;
    case (l_op)
      SHIFT_OP_SLL:  r = d << amt;
      SHIFT_OP_SRL:  r = d >> amt;
      SHIFT_OP_SRA:  r = $signed(d) >>> amt;
      SHIFT_OP_ROTR: r = (d >> amt) | (d << (WIDTH - amt));
      default:       r = d;
    endcase
    return r;
  endfunction

  assign advance = !valid_r || down_advance;

  // Combinational mux layers owned by this stage.
  always_comb begin
    shifted_s = up_data;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (up_shamt[FIRST_LAYER + k]) begin
        shifted_s = layer_shift(up_op, shifted_s, 1 << (FIRST_LAYER + k));
      end else begin
        shifted_s = shifted_s;
      end
    end
  end

  // Stage register: valid follows flush/advance, payload loads only on advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      op_r    <= 2'b00;
      shamt_r <= '0;
      data_r  <= '0;
      tag_r   <= '0;
    end else begin
      if (flush) begin
        valid_r <= 1'b0;
      end else if (advance) begin
        valid_r <= up_valid;
      end else begin
        valid_r <= valid_r;
      end
      if (advance) begin
        op_r    <= up_op;
        shamt_r <= up_shamt;
        data_r  <= shifted_s;
        tag_r   <= up_tag;
      end else begin
        op_r    <= op_r;
        shamt_r <= shamt_r;
        data_r  <= data_r;
        tag_r   <= tag_r;
      end
    end
  end

  assign valid = valid_r;
  assign op    = op_r;
  assign shamt = shamt_r;
  assign data  = data_r;
  assign tag   = tag_r;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROTR unit with valid/ready handshake and a passthrough tag.
// STAGES copies of shift_stage are chained; the advance chain runs back from out_ready.
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [$clog2(WIDTH)-1:0]  in_shamt,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int SW = shamt_width(WIDTH);

  logic              st_valid_s [STAGES];
  logic [1:0]        st_op_s    [STAGES];
  logic [SW-1:0]     st_shamt_s [STAGES];
  logic [WIDTH-1:0]  st_data_s  [STAGES];
  logic [TAG_W-1:0]  st_tag_s   [STAGES];
  logic              st_adv_s   [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int FL = stage_first_layer(SW, STAGES, i);
    localparam int NL = stage_num_layers(SW, STAGES, i);

    logic              up_valid_s;
    logic [1:0]        up_op_s;
    logic [SW-1:0]     up_shamt_s;
    logic [WIDTH-1:0]  up_data_s;
    logic [TAG_W-1:0]  up_tag_s;
    logic              down_adv_s;

    if (i == 0) begin : g_head
      assign up_valid_s = in_valid;
      assign up_op_s    = in_op;
      assign up_shamt_s = in_shamt;
      assign up_data_s  = in_data;
      assign up_tag_s   = in_tag;
    end else begin : g_body
      assign up_valid_s = st_valid_s[i-1];
      assign up_op_s    = st_op_s[i-1];
      assign up_shamt_s = st_shamt_s[i-1];
      assign up_data_s  = st_data_s[i-1];
      assign up_tag_s   = st_tag_s[i-1];
    end

    // The last stage drains into the consumer; the others into their successor.
    if (i == STAGES - 1) begin : g_tail
      assign down_adv_s = out_ready;
    end else begin : g_link
      assign down_adv_s = st_adv_s[i+1];
    end

    shift_stage #(
      .WIDTH       (WIDTH),
      .FIRST_LAYER (FL),
      .NUM_LAYERS  (NL),
      .TAG_W       (TAG_W)
    ) u_stage (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .up_valid     (up_valid_s),
      .up_op        (up_op_s),
      .up_shamt     (up_shamt_s),
      .up_data      (up_data_s),
      .up_tag       (up_tag_s),
      .down_advance (down_adv_s),
      .advance      (st_adv_s[i]),
      .valid        (st_valid_s[i]),
      .op           (st_op_s[i]),
      .shamt        (st_shamt_s[i]),
      .data         (st_data_s[i]),
      .tag          (st_tag_s[i])
    );
  end

  assign in_ready  = st_adv_s[0];
  assign out_valid = st_valid_s[STAGES-1];
  assign out_data  = st_data_s[STAGES-1];
  assign out_tag   = st_tag_s[STAGES-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: a bit-index reference model predicts each accepted
// operation, a negedge monitor pops and compares every output transfer.
module tb_shift_pipe;

  localparam int STAGES = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_data = 32'd0;
  logic [4:0]  in_shamt = 5'd0, in_tag = 5'd0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  shift_pipe #(.WIDTH(32), .STAGES(STAGES), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag));

  logic        iv16 = 1'b0, ir16, ov16;
  logic [1:0]  op16 = 2'b00;
  logic [15:0] d16 = 16'd0, od16;
  logic [3:0]  sh16 = 4'd0;
  logic [4:0]  t16 = 5'd0, ot16;

  shift_pipe #(.WIDTH(16), .STAGES(4), .TAG_W(5)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .in_op(op16),
    .in_data(d16), .in_shamt(sh16), .in_tag(t16), .flush(1'b0),
    .out_valid(ov16), .out_ready(1'b1), .out_data(od16), .out_tag(ot16));

  logic        iv64 = 1'b0, ir64, ov64;
  logic [1:0]  op64 = 2'b00;
  logic [63:0] d64 = 64'd0, od64;
  logic [5:0]  sh64 = 6'd0;
  logic [4:0]  t64 = 5'd0, ot64;

  shift_pipe #(.WIDTH(64), .STAGES(1), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .in_op(op64),
    .in_data(d64), .in_shamt(sh64), .in_tag(t64), .flush(1'b0),
    .out_valid(ov64), .out_ready(1'b1), .out_data(od64), .out_tag(ot64));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic check_lat = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result bit i comes from operand bit src; out-of-range sources give the fill bit.
  function automatic logic [63:0] ref_shift(input logic [1:0] op, input logic [63:0] d,
                                            input int sh, input int w);
    logic [63:0] r;
    int src;
    r = 64'd0;
    for (int i = 0; i < w; i++) begin
      case (op)
        2'b00:   src = i - sh;
        2'b01:   src = i + sh;
        2'b10:   src = i + sh;
        default: src = (i + sh) % w;
      endcase
      if (src >= 0 && src < w) r[i] = d[src];
      else if (op == 2'b10)     r[i] = d[w-1];
      else                      r[i] = 1'b0;
    end
    return r;
  endfunction

  // Monitor: compare output transfers, check hold-while-stalled, record input transfers.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [4:0]  prev_tag;
  always @(negedge clk) begin
    exp_t e;
    logic [63:0] r;
    if (reset) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(prev_data));
        check("hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got %h tag %0d expected no output", out_data, out_tag);
        end else begin
          e = sb.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_tag", 64'(out_tag), 64'(e.tag));
          if (check_lat) check("latency", 64'(cyc - e.cyc), 64'(STAGES));
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        r = ref_shift(in_op, {32'd0, in_data}, int'(in_shamt), 32);
        e.data = r[31:0];
        e.tag  = in_tag;
        e.cyc  = cyc;
        sb.push_back(e);
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                       input logic [4:0] tag, output int waits);
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh; in_tag = tag;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("issue_timeout", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic run16(input logic [1:0] op, input logic [15:0] d, input logic [3:0] sh,
                       input logic [4:0] tag);
    logic [63:0] exp;
    int c0, n;
    iv16 = 1'b1; op16 = op; d16 = d; sh16 = sh; t16 = tag;
    @(negedge clk);
    check("w16_ready", 64'(ir16), 64'd1);
    c0 = cyc;
    step();
    iv16 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov16 && n < 20) begin n++; @(negedge clk); end
    exp = ref_shift(op, {48'd0, d}, int'(sh), 16);
    check("w16_valid", 64'(ov16), 64'd1);
    check("w16_data", 64'(od16), exp);
    check("w16_tag", 64'(ot16), 64'(tag));
    check("w16_latency", 64'(cyc - c0), 64'd4);
    step();
  endtask

  task automatic run64(input logic [1:0] op, input logic [63:0] d, input logic [5:0] sh,
                       input logic [4:0] tag);
    logic [63:0] exp;
    int c0, n;
    iv64 = 1'b1; op64 = op; d64 = d; sh64 = sh; t64 = tag;
    @(negedge clk);
    check("w64_ready", 64'(ir64), 64'd1);
    c0 = cyc;
    step();
    iv64 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov64 && n < 20) begin n++; @(negedge clk); end
    exp = ref_shift(op, d, int'(sh), 64);
    check("w64_valid", 64'(ov64), 64'd1);
    check("w64_data", od64, exp);
    check("w64_tag", 64'(ot64), 64'(tag));
    check("w64_latency", 64'(cyc - c0), 64'd1);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int w, accepted;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    step();

    // Back-to-back basics with latency tracking.
    check_lat = 1'b1;
    issue(2'b01, 32'h0000_0004, 5'd1, 5'd16, w);
    issue(2'b00, 32'h0000_0002, 5'd3, 5'd17, w);
    issue(2'b10, 32'hFFFF_FF00, 5'd4, 5'd18, w);
    issue(2'b11, 32'h0000_0001, 5'd1, 5'd8, w);
    drain("drain_basic");

    // Edge amounts.
    issue(2'b01, 32'h8000_0000, 5'd31, 5'd1, w);
    issue(2'b10, 32'h8000_0000, 5'd31, 5'd2, w);
    for (int i = 0; i < 4; i++) issue(2'(i), 32'h1234_5678, 5'd0, 5'(i + 3), w);
    drain("drain_edges");
    check_lat = 1'b0;

    // Backpressure: only two ops fit while the consumer stalls.
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_op = 2'(i); in_data = $urandom; in_shamt = 5'($urandom);
      in_tag = 5'(20 + i);
      @(negedge clk);
      if (in_ready) accepted++;
      step();
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(accepted), 64'd2);
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    repeat (3) step();
    out_ready = 1'b1;
    drain("drain_bp");

    // Bubble collapse.
    out_ready = 1'b0;
    issue(2'b00, $urandom, 5'd7, 5'd10, w);
    step();
    issue(2'b11, $urandom, 5'd13, 5'd11, w);
    check("bubble_b_waits", 64'(w), 64'd0);
    repeat (2) step();
    out_ready = 1'b1;
    drain("drain_bubble");

    // Flush with two in flight; the same-cycle input is dropped.
    out_ready = 1'b0;
    issue(2'b01, $urandom, 5'd2, 5'd12, w);
    issue(2'b10, $urandom, 5'd9, 5'd13, w);
    in_valid = 1'b1; flush = 1'b1; in_tag = 5'd14;
    step();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      step();
    end

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 2'($urandom); in_data = $urandom; in_shamt = 5'($urandom);
      in_tag = 5'(i);
      step();
    end
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    step();
    issue(2'b10, 32'h8765_4321, 5'd5, 5'd30, w);
    drain("drain_after_reset");

    // Randomised traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 7;
      in_op = 2'($urandom); in_data = $urandom; in_shamt = 5'($urandom); in_tag = 5'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("drain_random");

    // Other parametrisations.
    run16(2'b10, 16'h8000, 4'd15, 5'd4);
    run64(2'b11, 64'd1, 6'd63, 5'd5);
    for (int i = 0; i < 10; i++) begin
      run16(2'($urandom), 16'($urandom), 4'($urandom), 5'($urandom));
      run64(2'($urandom), {32'($urandom), 32'($urandom)}, 6'($urandom), 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined shift/rotate unit; successor to the single-cycle SLL/SRL datapath shifter.
- Implements SLL, SRL, SRA, ROTR with variable amount, generalised width and stage count.
- Uses a valid/ready handshake and carries a destination-register tag.
- Sits between decode/regfile read and writeback, for the multi-cycle execution-unit work.

Parameters:
- WIDTH, 32, data width in bits; power of two, at least 8.
- STAGES, 2, pipeline register stages; 1 <= STAGES <= log2(WIDTH).
- TAG_W, 5, width of the passthrough tag (destination register number).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  the input operation is valid.
- in_ready  out  1  the unit accepts input this cycle.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- in_data  in  WIDTH  operand to shift (rt).
- in_shamt  in  log2(WIDTH)  shift amount; the caller supplies the low bits of rs or the shamt field.
- in_tag  in  TAG_W  opaque tag, returned with the result.
- flush  in  1  discard all in-flight operations.
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer accepts the result.
- out_data  out  WIDTH  shift result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Shifter structure:
  - Logarithmic shifter of log2(WIDTH) mux layers; layer k shifts by 2^k when shamt bit k is 1.
  - Layers are distributed over STAGES register stages as evenly as possible, ceil-first from the input side.
  - Each stage register holds: valid, op, the remaining shamt bits, the partial data, and the tag.
- Operation rules:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with in_data[WIDTH-1], captured at entry.
  - ROTR: bits leaving at bit 0 re-enter at WIDTH-1.
  - shamt = 0 passes in_data unchanged for every op.
  - Shift amounts never exceed WIDTH-1; there is no overflow case.
- Latency: an accepted operation appears on out_valid exactly STAGES cycles later when the pipe never stalls.
- Throughput: one operation per cycle.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Stage i advances when it is empty or stage i+1 advances; the last stage advances when it is empty or out_ready is high.
  - in_ready = stage 0 advances. It is combinational from out_ready through the stall chain, with no combinational path from in_valid.
  - Bubbles collapse: an empty stage accepts while later stages are stalled.
  - While out_valid && !out_ready, out_data and out_tag hold stable.
  - Data registers load only on advance; contents of invalid stages are don't-care.
- flush:
  - Clears every stage valid bit at the next edge.
  - An input presented in the same cycle as flush is dropped, and in_ready stays as computed.
  - flush while the pipe is empty has no effect.
- reset:
  - Forces all valid bits to 0, so out_valid = 0 and in_ready = 1 in the cycle after reset deasserts.
  - out_data and out_tag reset to 0.
  - Reset mid-operation silently drops all in-flight operations.
  - Reset has priority over flush and over input acceptance.
- Simultaneous events:
  - A full pipe with out_ready = 1 accepts a new input and retires the oldest result in the same cycle.
  - Order is strictly FIFO; results never reorder.

Decomposition:
- Shared package (processor constants include):
  - SHIFT_OP_SLL/SRL/SRA/ROTR 2-bit encodings.
  - A function shamt_width(WIDTH) = $clog2(WIDTH).
  - The layer-per-stage split function.
- Sub-module shift_stage:
  - Parameters: WIDTH, FIRST_LAYER, NUM_LAYERS, TAG_W.
  - Contains the combinational layers plus its pipeline register and local valid/advance logic.
  - shift_pipe instantiates STAGES copies in a generate loop.

Test Plan:
- Defaults, back-to-back with out_ready = 1:
  - SRL 0x04 by 1 -> 0x02.
  - SLL 0x02 by 3 -> 0x10.
  - SRA 0xFFFFFF00 by 4 -> 0xFFFFFFF0.
  - ROTR 0x00000001 by 1 -> 0x80000000.
  - Each result arrives 2 cycles after acceptance with tags 16, 17, 18, 8 in order.
- Edge amounts:
  - SRL 0x80000000 by 31 -> 0x1.
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
  - Any op with shamt 0 on 0x12345678 -> 0x12345678.
- Backpressure:
  - Hold out_ready = 0, issue 4 ops -> in_ready falls after 2 accepted; out_data stays stable.
  - Release out_ready -> results drain in FIFO order with no loss or duplication.
- Bubble collapse:
  - Issue op A, idle one cycle, issue op B while out_ready = 0 -> B still accepted; A and B drain in order once out_ready = 1.
- Flush and reset:
  - Flush with 2 ops in flight -> out_valid stays 0 for the next STAGES cycles.
  - Assert reset mid-stream -> out_valid = 0 and in_ready = 1 after reset; the next op completes normally.
- Parametrisation:
  - WIDTH = 16, STAGES = 4: SRA 0x8000 by 15 -> 0xFFFF, latency 4.
  - WIDTH = 64, STAGES = 1: ROTR 0x1 by 63 -> 0x2, latency 1.
